// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared width and word type for the ripple-carry adder slice
package rca_pkg;
  localparam int RCA_WIDTH = 4;
  typedef logic [RCA_WIDTH-1:0] rca_word_t;
endpackage

// File: rtl/ripple_carry_adder_4bit_if.sv
// rtl/ripple_carry_adder_4bit_if.sv - operand/result bundle for the adder
// Ovf/Ovf_q exist only when RCA_OVERFLOW_EN is defined.
interface ripple_carry_adder_4bit_if
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic [WIDTH-1:0] Sum_q;
  logic             Cout_q;
  logic             out_valid;
`ifdef RCA_OVERFLOW_EN
  logic             Ovf;
  logic             Ovf_q;

  modport master (
    output A, B, Cin, in_valid,
    input  Sum, Cout, Sum_q, Cout_q, out_valid, Ovf, Ovf_q
  );
  modport slave (
    input  A, B, Cin, in_valid,
    output Sum, Cout, Sum_q, Cout_q, out_valid, Ovf, Ovf_q
  );
`else
  modport master (
    output A, B, Cin, in_valid,
    input  Sum, Cout, Sum_q, Cout_q, out_valid
  );
  modport slave (
    input  A, B, Cin, in_valid,
    output Sum, Cout, Sum_q, Cout_q, out_valid
  );
`endif
endinterface

// File: rtl/full_adder_1bit.sv
// rtl/full_adder_1bit.sv - single full-adder cell used in the carry chain
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/ripple_carry_adder_4bit.sv
// rtl/ripple_carry_adder_4bit.sv - ripple-carry adder with a registered result copy
// Optional signed overflow outputs under RCA_OVERFLOW_EN.
module ripple_carry_adder_4bit
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ripple_carry_adder_4bit_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_1bit u_fa (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign bus.Sum  = s;
  assign bus.Cout = c[WIDTH];

`ifdef RCA_OVERFLOW_EN
  // Carry into the sign bit disagreeing with carry out marks signed overflow.
  assign bus.Ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Sum_q     <= '0;
      bus.Cout_q    <= 1'b0;
      bus.Ovf_q     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.Sum_q     <= s;
      bus.Cout_q    <= c[WIDTH];
      bus.Ovf_q     <= c[WIDTH] ^ c[WIDTH-1];
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Sum_q     <= '0;
      bus.Cout_q    <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.Sum_q     <= s;
      bus.Cout_q    <= c[WIDTH];
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// tb/tb_ripple_carry_adder_4bit.sv - self-checking bench for ripple_carry_adder_4bit
// Covers RCA_OVERFLOW_EN outputs when that macro is defined.
module tb_ripple_carry_adder_4bit;
  import rca_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ripple_carry_adder_4bit_if #(.WIDTH(RCA_WIDTH)) bus ();

  ripple_carry_adder_4bit #(.WIDTH(RCA_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference registered state, updated by the bench's own reading of the rules.
  int exp_sum_q;
  int exp_cout_q;
  int exp_valid;
  int exp_ovf_q;

  function automatic int ref_total(int a, int b, int ci);
    return a + b + ci;
  endfunction

  function automatic int ref_ovf(int a, int b, int ci);
    int sa, sb, t;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    t  = sa + sb + ci;
    return (t > 7 || t < -8) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_comb(input string tag, input int a, input int b, input int ci);
    int t;
    t = ref_total(a, b, ci);
    check(tag, 32'({bus.Cout, bus.Sum}), t);
`ifdef RCA_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(bus.Ovf), ref_ovf(a, b, ci));
`endif
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sum_q"}, 32'(bus.Sum_q), exp_sum_q);
    check({tag, "_cout_q"}, 32'(bus.Cout_q), exp_cout_q);
    check({tag, "_out_valid"}, 32'(bus.out_valid), exp_valid);
`ifdef RCA_OVERFLOW_EN
    check({tag, "_ovf_q"}, 32'(bus.Ovf_q), exp_ovf_q);
`endif
  endtask

  // Applies one clocked step and advances the reference registers.
  task automatic step(input int a, input int b, input int ci, input int iv, input int rn);
    int t;
    bus.A        = 4'(a);
    bus.B        = 4'(b);
    bus.Cin      = ci[0];
    bus.in_valid = iv[0];
    rst_n        = rn[0];
    @(posedge clk);
    #1;
    t = ref_total(a, b, ci);
    if (rn == 0) begin
      exp_sum_q = 0; exp_cout_q = 0; exp_valid = 0; exp_ovf_q = 0;
    end else if (iv != 0) begin
      exp_sum_q  = t % 16;
      exp_cout_q = t / 16;
      exp_ovf_q  = ref_ovf(a, b, ci);
      exp_valid  = 1;
    end else begin
      exp_valid = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, ci, iv, rn;
    vectors = 0; miscompares = 0;
    exp_sum_q = 0; exp_cout_q = 0; exp_valid = 0; exp_ovf_q = 0;
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.in_valid = 1'b0; rst_n = 1'b0;

    // Reset state.
    step(0, 0, 0, 0, 0);
    check_regs("reset");

    // Exhaustive combinational sweep with the registers idle.
    for (int i = 0; i < 512; i++) begin
      a = (i >> 5) & 15; b = (i >> 1) & 15; ci = i & 1;
      bus.A = 4'(a); bus.B = 4'(b); bus.Cin = ci[0];
      #1;
      check_comb("exhaustive", a, b, ci);
    end

    // Randomized combinational vectors.
    for (int i = 0; i < 200; i++) begin
      a = int'($urandom_range(15)); b = int'($urandom_range(15)); ci = int'($urandom_range(1));
      bus.A = 4'(a); bus.B = 4'(b); bus.Cin = ci[0];
      #1;
      check_comb("random", a, b, ci);
    end

    // Wrap-around and corner operands.
    bus.A = 4'hF; bus.B = 4'hF; bus.Cin = 1'b1; #1;
    check("corner_ff1", 32'({bus.Cout, bus.Sum}), 32'h1F);
    bus.A = 4'hF; bus.B = 4'h0; bus.Cin = 1'b1; #1;
    check("corner_f01", 32'({bus.Cout, bus.Sum}), 32'h10);
    bus.A = 4'h0; bus.B = 4'h0; bus.Cin = 1'b0; #1;
    check("corner_000", 32'({bus.Cout, bus.Sum}), 32'h00);
    bus.A = 4'h8; bus.B = 4'h8; bus.Cin = 1'b0; #1;
    check("corner_880", 32'({bus.Cout, bus.Sum}), 32'h10);
`ifdef RCA_OVERFLOW_EN
    bus.A = 4'h7; bus.B = 4'h1; bus.Cin = 1'b0; #1;
    check("ovf_7_1", 32'(bus.Ovf), 1);
    bus.A = 4'h8; bus.B = 4'h8; bus.Cin = 1'b0; #1;
    check("ovf_8_8", 32'(bus.Ovf), 1);
    bus.A = 4'h3; bus.B = 4'h2; bus.Cin = 1'b0; #1;
    check("ovf_3_2", 32'(bus.Ovf), 0);
`endif

    // Directed registered sequence.
    step(0, 0, 0, 0, 0);
    check_regs("reg_reset");
    step(9, 7, 1, 1, 1);
    check("reg_capture_sum_q", 32'(bus.Sum_q), 1);
    check("reg_capture_cout_q", 32'(bus.Cout_q), 1);
    check("reg_capture_valid", 32'(bus.out_valid), 1);
    step(2, 3, 0, 0, 1);
    check("reg_hold_sum_q", 32'(bus.Sum_q), 1);
    check("reg_hold_valid", 32'(bus.out_valid), 0);
    check_regs("reg_hold");

    // Reset beats in_valid; combinational path keeps working during reset.
    step(5, 6, 1, 1, 1);
    check_regs("pre_prio");
    step(5, 6, 1, 1, 0);
    check_regs("reset_prio");
    check_comb("comb_in_reset", 5, 6, 1);

    // Randomized registered stream with occasional mid-stream reset.
    for (int i = 0; i < 100; i++) begin
      a  = int'($urandom_range(15));
      b  = int'($urandom_range(15));
      ci = int'($urandom_range(1));
      iv = int'($urandom_range(1));
      rn = ($urandom_range(9) == 0) ? 0 : 1;
      step(a, b, ci, iv, rn);
      check_regs("rand_reg");
      check_comb("rand_reg_comb", a, b, ci);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
